// File: rtl/int_divider.sv
// int_divider
//   Iterative RV32M-style integer divider (DIV, DIVU, REM, REMU). Operands are
//   captured on the accepting edge. The first RUN cycle loads the magnitudes.
//   WIDTH restoring shift-subtract steps follow, one quotient bit per cycle,
//   MSB first. FIX applies sign correction and the divide-by-zero / signed
//   overflow results. DONE presents the result for one cycle.
//
//   A result is reported WIDTH+2 edges after the accepting edge.
//
//   Optional feature (macro INT_DIVIDER_EARLY_OUT_EN): divide-by-zero and
//   signed overflow go straight from accept to FIX. Their done then comes
//   1 edge after the accepting edge. With the macro undefined, every
//   operation takes the full latency.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new operation (sampled only when busy=0)
//   op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   numerator, captured with start
//   divisor   in   denominator, captured with start
//   busy      out  operation in flight (RUN or FIX)
//   done      out  one-cycle pulse, result valid
//   result    out  quotient or remainder, held until the next accepted start
module int_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             signed_op;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] fix_val;

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Cases whose result does not come from the shift-subtract loop.
  function automatic logic is_special(input logic [1:0]       o,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    return (b == '0) || (!o[0] && (a == MIN_NEG) && (b == '1));
  endfunction

  // op[0]=0 selects the signed flavours (DIV, REM).
  assign signed_op = ~op_q[0];
  assign dvd_mag   = cond_neg(dvd_q, signed_op & dvd_q[WIDTH-1]);
  assign dvs_mag   = cond_neg(dvs_q, signed_op & dvs_q[WIDTH-1]);

  // The WIDTH+1-bit partial remainder is the stored remainder shifted left,
  // with the next dividend bit taken from the top of the quotient register.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_mag};

  always_comb begin
    fix_val = '0;
    if (dvs_q == '0) begin
      fix_val = op_q[1] ? dvd_q : '1;
    end else if (is_special(op_q, dvd_q, dvs_q)) begin
      fix_val = op_q[1] ? '0 : dvd_q;
    end else if (op_q[1]) begin
      fix_val = cond_neg(rem_q, signed_op & dvd_q[WIDTH-1]);
    end else begin
      fix_val = cond_neg(quo_q, signed_op & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d  = op;
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
`ifdef INT_DIVIDER_EARLY_OUT_EN
          state_d = is_special(op, dividend, divisor) ? FIX : RUN;
`else
          state_d = RUN;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (cnt_q == '0) begin
          // Load step: quotient register starts out holding |dividend|.
          rem_d = '0;
          quo_d = dvd_mag;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Restore (keep shifted value) when the trial subtract underflows.
          rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_int_divider.sv
// tb_int_divider
//   Table of directed vectors plus random vectors checked against a reference
//   model. Hand-written sequences cover ignored start while busy, reset during
//   an operation, back-to-back start in DONE and start right after reset.
//   Expected results are queued when an operation is launched and popped when
//   done is seen.
module tb_int_divider;

  localparam int W = 32;

`ifdef INT_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           special;
  } vec_t;

  typedef struct {
    logic [W-1:0] exp;
    int           lat;
    string        name;
  } exp_t;

  vec_t tbl[17];
  exp_t sb[$];

  int_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(bit sp);
    return (EARLY && sp) ? 1 : 34;
  endfunction

  function automatic logic [W-1:0] ref_div(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'd0:    r = $signed(a) / $signed(b);
      2'd1:    r = a / b;
      2'd2:    r = $signed(a) % $signed(b);
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic bit ref_special(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    return (b == '0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive a request (away from the clock edge) and queue its expectation.
  task automatic drive_start(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                             logic [W-1:0] exp, bit sp, string name);
    exp_t e;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    e.exp    = exp;
    e.lat    = exp_lat(sp);
    e.name   = name;
    sb.push_back(e);
  endtask

  // Next posedge is the accepting edge. Optionally pulse start with other
  // operands just before edge inject_k (counted from the accepting edge).
  task automatic wait_done(int inject_k);
    exp_t e;
    bit   got;
    int   lat;
    got = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 100; k++) begin
      if (k == inject_k) begin
        start = 1'b1; op = 2'd1; dividend = 32'd1000; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got done with no queued expectation");
    end else begin
      e = sb.pop_front();
      if (!got) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got no done in 100 edges required done", e.name);
      end else begin
        check({e.name, "_result"}, result, e.exp);
        check({e.name, "_latency"}, 32'(lat), 32'(e.lat));
        check({e.name, "_busy_with_done"}, {31'b0, busy}, 32'd0);
      end
    end
  endtask

  initial begin
    int ndone;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{2'd1, 32'd100,        32'd7,        32'd14,         1'b0};
    tbl[1]  = '{2'd3, 32'd100,        32'd7,        32'd2,          1'b0};
    tbl[2]  = '{2'd0, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  1'b0};
    tbl[3]  = '{2'd2, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE,  1'b0};
    tbl[4]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[5]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[6]  = '{2'd1, 32'd5,          32'd0,        32'hFFFF_FFFF,  1'b1};
    tbl[7]  = '{2'd3, 32'd5,          32'd0,        32'd5,          1'b1};
    tbl[8]  = '{2'd0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    tbl[9]  = '{2'd2, 32'd100,        32'hFFFF_FFF9, 32'd2,         1'b0};
    tbl[10] = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0};
    tbl[11] = '{2'd0, 32'd5,          32'd0,        32'hFFFF_FFFF,  1'b1};
    tbl[12] = '{2'd2, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB,  1'b1};
    tbl[13] = '{2'd1, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  1'b0};
    tbl[14] = '{2'd3, 32'hFFFF_FFFF,  32'h10,       32'hF,          1'b0};
    tbl[15] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[16] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    #1;
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Directed table, with an idle cycle between operations.
    foreach (tbl[i]) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].special,
                  $sformatf("tbl%0d", i));
      wait_done(0);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) rb = ~rb + 32'd1;
      drive_start(ro, ra, rb, ref_div(ro, ra, rb), ref_special(ro, ra, rb),
                  $sformatf("rnd%0d", i));
      wait_done(0);
      @(posedge clk); #1;
    end

    // Start pulsed at edge 10 of a running op is ignored and not queued.
    drive_start(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "ignore_start");
    wait_done(10);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("no_queued_op", 32'(ndone), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    drive_start(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "b2b_first");
    wait_done(0);
    drive_start(2'd1, 32'd9, 32'd3, 32'd3, 1'b0, "b2b_second");
    wait_done(0);
    @(posedge clk); #1;

    // Reset at edge 15 of an operation aborts it immediately.
    drive_start(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "aborted");
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy",   {31'b0, busy}, 32'd0);
    check("midreset_done",   {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("no_done_after_abort", 32'(ndone), 32'd0);

    // Start accepted on the first edge after reset release.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    drive_start(2'd1, 32'd9, 32'd3, 32'd3, 1'b0, "post_reset");
    wait_done(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
